alu_decoder: RTL and testbench
==============================

Name: alu_decoder

Overview:
Decode stage that sits in front of the execute ALU. It accepts 32-bit RV64IM instruction words over a valid/ready handshake and translates each into the ALU control fields: opcode, instr_type, immediate, shamt, register indices and word_op. The results are held in one pipeline register, so each decoded instruction appears at the outputs exactly one cycle after it is accepted. It also flags illegal encodings and counts the instructions it issues.

Parameters:
CNT_W, 32, width of the issued-instruction and illegal-instruction counters.

Ports:
clk  input  1  clock; all state updates on posedge.
reset_n  input  1  synchronous, active-low reset; sampled on posedge clk.
flush  input  1  drops the held instruction (branch redirect).
in_valid  input  1  instr/in_pc are valid.
in_ready  output  1  decoder accepts this cycle.
instr  input  32  raw instruction word.
in_pc  input  64  PC of instr.
out_valid  output  1  decoded fields are valid.
out_ready  input  1  execute stage consumes this cycle.
out_pc  output  64  registered in_pc.
opcode  output  11  ALU operation, one of the Alu.defs codes.
instr_type  output  4  `RTYPE/`ITYPE/`STYPE/`BTYPE/`UTYPE/`JTYPE.
immediate  output  32  sign-correct immediate for the format.
shamt  output  6  shift amount for immediate shifts, else 0.
rs1, rs2, rd  output  5 each  register indices.
word_op  output  1  instruction is an RV64 W-variant.
illegal  output  1  encoding is not recognised.
issued_cnt  output  CNT_W  count of output handshakes.
illegal_cnt  output  CNT_W  count of output handshakes with illegal=1.

Behaviour:
- Reset (reset_n=0 at posedge):
  - out_valid=0, opcode=`NOTHING, every other output field 0, both counters 0.
  - Reset takes priority over flush and over both handshakes.
  - Reset mid-stream discards the held instruction.
- in_ready = !out_valid || out_ready. This is a combinational pass-through, giving a throughput of 1 instruction/cycle.
- Accept = in_valid && in_ready && !flush. On accept, the decode result and in_pc are registered and out_valid=1 next cycle (latency 1).
- Output handshake (out_valid && out_ready) without a simultaneous accept: out_valid goes to 0. With a simultaneous accept, the register is overwritten with the new instruction and out_valid stays 1.
- Fields hold stable while out_valid && !out_ready.
- flush=1: out_valid goes to 0 next cycle and no accept occurs that cycle. A handshake still counts if out_ready was high in the same cycle.
- Counters increment on output handshake only and wrap modulo 2^CNT_W.
- Decode, by major opcode instr[6:0]:
  - OP-IMM / OP-IMM-32 (ITYPE, imm=sext(instr[31:20])): ADDI→`ADD, SLTI→`LESS, SLTIU→`SLTIU, XORI→`XOR, ORI→`OR, ANDI→`AND.
  - Immediate shifts: SLLI→`SLL, SRLI→`SRL, SRAI→`SRA, with shamt=instr[25:20].
  - W immediate forms set word_op=1. SLLIW/SRLIW/SRAIW with instr[25]=1 are illegal.
  - OP / OP-32 (RTYPE, imm=0), funct7=0000000: ADD, SLL, SLT→`LESS, SLTU→`LESSU, XOR, SRL, OR, AND.
  - OP / OP-32, funct7=0100000: SUB, SRA.
  - OP / OP-32, funct7=0000001: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - OP-32 accepts only ADDW/SUBW/SLLW/SRLW/SRAW/MULW/DIVW/DIVUW/REMW/REMUW. Any other OP-32 funct is illegal.
  - LOAD → `ADD, ITYPE. STORE → `ADD, STYPE, imm=sext({instr[31:25],instr[11:7]}).
  - BRANCH → BTYPE, imm=sext B-format with bit0=0: BEQ→`EQUAL, BNE→`NEQ, BLT→`LESS, BGE→`GTE, BLTU→`LESSU, BGEU→`GTEU.
  - LUI / AUIPC → `IMMVAL, UTYPE, imm={instr[31:12],12'b0}.
  - JALR → `ADD, ITYPE. JAL → `NOTHING, JTYPE, imm=sext J-format with bit0=0.
  - Anything else, including instr[1:0]≠11: illegal=1, opcode=`NOTHING. It is still issued through the handshake.
- rs1/rs2/rd are always taken from instr[19:15]/[24:20]/[11:7]. Unused indices are driven to 0 for UTYPE/JTYPE (rs1, rs2) and for STYPE/BTYPE (rd).

Test Plan:
- Back-to-back stream, out_ready=1: ADDI x1,x0,-5 (0xFFB00093), then MUL x3,x1,x2 → cycle+1 opcode=`ADD, ITYPE, imm=0xFFFFFFFB, rd=1; next cycle opcode=`MUL, RTYPE; in_ready held 1; issued_cnt=2.
- Backpressure: out_ready=0 for 3 cycles holding SRAI x5,x6,63 → fields stable, shamt=63, opcode=`SRA, in_ready=0. Release → handshake, then the next instruction accepted the same cycle.
- Illegal: 0xFFFFFFFF and SLLIW with instr[25]=1 → illegal=1, opcode=`NOTHING, illegal_cnt=2.
- Formats: SW x2,-4(x1) → STYPE imm=0xFFFFFFFC, rd=0. BGEU offset -8 → `GTEU, imm=0xFFFFFFF8. LUI 0x12345 → `IMMVAL, imm=0x12345000.
- Flush with in_valid=1 and out_valid=1 → out_valid=0 next cycle, instruction not accepted, counters unchanged when out_ready=0.
- reset_n=0 mid-stream while out_valid=1 → next cycle out_valid=0, opcode=`NOTHING, counters 0. Counter wrap with CNT_W=4: 16 handshakes → issued_cnt=0.

Source files
------------

// File: rtl/alu_decoder.sv
// alu_decoder: RV64IM decode stage in front of the execute ALU.
// One pipeline register holds the decoded fields; latency is one cycle.
// Handshake: a transfer happens on a rising clk edge where valid && ready
// are both high; valid-side payload must stay stable until that transfer,
// and ready may depend combinationally on the downstream ready.

`ifndef ALU_DEFS_SV
`define ALU_DEFS_SV
`define NOTHING 11'd0
`define ADD     11'd1
`define SUB     11'd2
`define SLL     11'd3
`define LESS    11'd4
`define LESSU   11'd5
`define SLTIU   11'd6
`define XOR     11'd7
`define SRL     11'd8
`define SRA     11'd9
`define OR      11'd10
`define AND     11'd11
`define MUL     11'd12
`define MULH    11'd13
`define MULHSU  11'd14
`define MULHU   11'd15
`define DIV     11'd16
`define DIVU    11'd17
`define REM     11'd18
`define REMU    11'd19
`define EQUAL   11'd20
`define NEQ     11'd21
`define GTE     11'd22
`define GTEU    11'd23
`define IMMVAL  11'd24
`define RTYPE   4'd1
`define ITYPE   4'd2
`define STYPE   4'd3
`define BTYPE   4'd4
`define UTYPE   4'd5
`define JTYPE   4'd6
`endif

module alu_decoder #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [63:0]      in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_pc,
    output logic [10:0]      opcode,
    output logic [3:0]       instr_type,
    output logic [31:0]      immediate,
    output logic [5:0]       shamt,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [4:0]       rd,
    output logic             word_op,
    output logic             illegal,
    output logic [CNT_W-1:0] issued_cnt,
    output logic [CNT_W-1:0] illegal_cnt
);

    logic [6:0] major;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       accept;
    logic       out_hs;

    logic [10:0] d_op;
    logic [3:0]  d_type;
    logic [31:0] d_imm;
    logic [5:0]  d_shamt;
    logic [4:0]  d_rs1;
    logic [4:0]  d_rs2;
    logic [4:0]  d_rd;
    logic        d_word;
    logic        d_legal;

    assign major    = instr[6:0];
    assign funct3   = instr[14:12];
    assign funct7   = instr[31:25];
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;
    assign out_hs   = out_valid && out_ready;

    // Combinational decode of the incoming word into ALU control fields.
    always_comb begin
        d_op    = `NOTHING;
        d_type  = 4'd0;
        d_imm   = 32'd0;
        d_shamt = 6'd0;
        d_word  = 1'b0;
        d_legal = 1'b0;
        case (major)
            7'b0010011, 7'b0011011: begin  // OP-IMM / OP-IMM-32
                d_type  = `ITYPE;
                d_imm   = {{20{instr[31]}}, instr[31:20]};
                d_word  = major[3];
                d_legal = 1'b1;
                case (funct3)
                    3'd0: d_op = `ADD;
                    3'd1: begin
                        d_op    = `SLL;
                        d_shamt = instr[25:20];
                        d_legal = major[3] ? (funct7 == 7'h00) : (instr[31:26] == 6'h00);
                    end
                    3'd5: begin
                        d_op    = instr[30] ? `SRA : `SRL;
                        d_shamt = instr[25:20];
                        d_legal = major[3] ? (funct7 == 7'h00 || funct7 == 7'h20)
                                           : (instr[31:26] == 6'h00 || instr[31:26] == 6'h10);
                    end
                    3'd2: begin d_op = `LESS;  d_legal = !major[3]; end
                    3'd3: begin d_op = `SLTIU; d_legal = !major[3]; end
                    3'd4: begin d_op = `XOR;   d_legal = !major[3]; end
                    3'd6: begin d_op = `OR;    d_legal = !major[3]; end
                    default: begin d_op = `AND; d_legal = !major[3]; end
                endcase
            end
            7'b0110011, 7'b0111011: begin  // OP / OP-32
                d_type  = `RTYPE;
                d_word  = major[3];
                d_legal = 1'b1;
                case ({funct7, funct3})
                    10'b0000000_000: d_op = `ADD;
                    10'b0000000_001: d_op = `SLL;
                    10'b0000000_010: begin d_op = `LESS;   d_legal = !major[3]; end
                    10'b0000000_011: begin d_op = `LESSU;  d_legal = !major[3]; end
                    10'b0000000_100: begin d_op = `XOR;    d_legal = !major[3]; end
                    10'b0000000_101: d_op = `SRL;
                    10'b0000000_110: begin d_op = `OR;     d_legal = !major[3]; end
                    10'b0000000_111: begin d_op = `AND;    d_legal = !major[3]; end
                    10'b0100000_000: d_op = `SUB;
                    10'b0100000_101: d_op = `SRA;
                    10'b0000001_000: d_op = `MUL;
                    10'b0000001_001: begin d_op = `MULH;   d_legal = !major[3]; end
                    10'b0000001_010: begin d_op = `MULHSU; d_legal = !major[3]; end
                    10'b0000001_011: begin d_op = `MULHU;  d_legal = !major[3]; end
                    10'b0000001_100: d_op = `DIV;
                    10'b0000001_101: d_op = `DIVU;
                    10'b0000001_110: d_op = `REM;
                    10'b0000001_111: d_op = `REMU;
                    default:         d_legal = 1'b0;
                endcase
            end
            7'b0000011: begin  // LOAD: funct3=7 has no RV64 load
                d_op    = `ADD;
                d_type  = `ITYPE;
                d_imm   = {{20{instr[31]}}, instr[31:20]};
                d_legal = (funct3 != 3'd7);
            end
            7'b0100011: begin  // STORE: SB/SH/SW/SD only
                d_op    = `ADD;
                d_type  = `STYPE;
                d_imm   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                d_legal = !funct3[2];
            end
            7'b1100011: begin  // BRANCH
                d_type  = `BTYPE;
                d_imm   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                d_legal = 1'b1;
                case (funct3)
                    3'd0: d_op = `EQUAL;
                    3'd1: d_op = `NEQ;
                    3'd4: d_op = `LESS;
                    3'd5: d_op = `GTE;
                    3'd6: d_op = `LESSU;
                    3'd7: d_op = `GTEU;
                    default: d_legal = 1'b0;
                endcase
            end
            7'b0110111, 7'b0010111: begin  // LUI / AUIPC
                d_op    = `IMMVAL;
                d_type  = `UTYPE;
                d_imm   = {instr[31:12], 12'd0};
                d_legal = 1'b1;
            end
            7'b1100111: begin  // JALR
                d_op    = `ADD;
                d_type  = `ITYPE;
                d_imm   = {{20{instr[31]}}, instr[31:20]};
                d_legal = (funct3 == 3'd0);
            end
            7'b1101111: begin  // JAL
                d_op    = `NOTHING;
                d_type  = `JTYPE;
                d_imm   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                d_legal = 1'b1;
            end
            default: d_legal = 1'b0;
        endcase

        // Illegal encodings carry no ALU meaning: clear every control field.
        if (!d_legal) begin
            d_op    = `NOTHING;
            d_type  = 4'd0;
            d_imm   = 32'd0;
            d_shamt = 6'd0;
            d_word  = 1'b0;
        end
    end

    // Register indices come straight from the word; unused ones are zeroed by format.
    always_comb begin
        d_rs1 = instr[19:15];
        d_rs2 = instr[24:20];
        d_rd  = instr[11:7];
        if (d_type == `UTYPE || d_type == `JTYPE) begin
            d_rs1 = 5'd0;
            d_rs2 = 5'd0;
        end
        if (d_type == `STYPE || d_type == `BTYPE) begin
            d_rd = 5'd0;
        end
    end

    // Pipeline register, occupancy flag and handshake counters.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid   <= 1'b0;
            out_pc      <= 64'd0;
            opcode      <= `NOTHING;
            instr_type  <= 4'd0;
            immediate   <= 32'd0;
            shamt       <= 6'd0;
            rs1         <= 5'd0;
            rs2         <= 5'd0;
            rd          <= 5'd0;
            word_op     <= 1'b0;
            illegal     <= 1'b0;
            issued_cnt  <= '0;
            illegal_cnt <= '0;
        end else begin
            if (out_hs) begin
                issued_cnt <= issued_cnt + 1'b1;
                if (illegal) begin
                    illegal_cnt <= illegal_cnt + 1'b1;
                end
            end
            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid  <= 1'b1;
                out_pc     <= in_pc;
                opcode     <= d_op;
                instr_type <= d_type;
                immediate  <= d_imm;
                shamt      <= d_shamt;
                rs1        <= d_rs1;
                rs2        <= d_rs2;
                rd         <= d_rd;
                word_op    <= d_word;
                illegal    <= !d_legal;
            end else if (out_hs) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_decoder.sv
// tb_alu_decoder: directed vector table plus hand-written sequences for
// backpressure, flush, mid-stream reset and counter wrap (CNT_W=4).

module tb_alu_decoder;

    localparam int CNT_W = 4;

    localparam logic [10:0] OP_NOTHING = 11'd0;
    localparam logic [10:0] OP_ADD     = 11'd1;
    localparam logic [10:0] OP_SUB     = 11'd2;
    localparam logic [10:0] OP_SLL     = 11'd3;
    localparam logic [10:0] OP_SLTIU   = 11'd6;
    localparam logic [10:0] OP_SRA     = 11'd9;
    localparam logic [10:0] OP_MUL     = 11'd12;
    localparam logic [10:0] OP_DIVU    = 11'd17;
    localparam logic [10:0] OP_GTEU    = 11'd23;
    localparam logic [10:0] OP_IMMVAL  = 11'd24;
    localparam logic [3:0]  T_NONE = 4'd0;
    localparam logic [3:0]  T_R    = 4'd1;
    localparam logic [3:0]  T_I    = 4'd2;
    localparam logic [3:0]  T_S    = 4'd3;
    localparam logic [3:0]  T_B    = 4'd4;
    localparam logic [3:0]  T_U    = 4'd5;
    localparam logic [3:0]  T_J    = 4'd6;

    localparam logic [31:0] I_ADDI  = 32'hFFB00093;
    localparam logic [31:0] I_MUL   = 32'h022081B3;
    localparam logic [31:0] I_SRAI  = 32'h43F35293;
    localparam logic [31:0] I_LUI   = 32'h123453B7;
    localparam logic [31:0] I_ONES  = 32'hFFFFFFFF;
    localparam int NV = 16;

    typedef struct {
        logic [31:0] instr;
        logic [10:0] op;
        logic [3:0]  typ;
        logic [31:0] imm;
        logic [5:0]  shamt;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        word_op;
        logic        illegal;
    } vec_t;

    logic             clk;
    logic             reset_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr;
    logic [63:0]      in_pc;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_pc;
    logic [10:0]      opcode;
    logic [3:0]       instr_type;
    logic [31:0]      immediate;
    logic [5:0]       shamt;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic             word_op;
    logic             illegal;
    logic [CNT_W-1:0] issued_cnt;
    logic [CNT_W-1:0] illegal_cnt;

    vec_t             vecs [NV];
    logic [63:0]      exp_q [$];
    logic [CNT_W-1:0] exp_iss;
    logic [CNT_W-1:0] exp_ill;
    int               n_cmp;
    int               n_err;

    alu_decoder #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .opcode(opcode), .instr_type(instr_type), .immediate(immediate),
        .shamt(shamt), .rs1(rs1), .rs2(rs2), .rd(rd), .word_op(word_op),
        .illegal(illegal), .issued_cnt(issued_cnt), .illegal_cnt(illegal_cnt)
    );

    // Clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] i, input logic [10:0] op, input logic [3:0] t,
                                input logic [31:0] imm, input logic [5:0] sh, input logic [4:0] a,
                                input logic [4:0] b, input logic [4:0] d, input logic w, input logic il);
        vec_t v;
        v.instr = i; v.op = op; v.typ = t; v.imm = imm; v.shamt = sh;
        v.rs1 = a; v.rs2 = b; v.rd = d; v.word_op = w; v.illegal = il;
        return v;
    endfunction

    task automatic check_fields(input string tag, input vec_t v);
        check({tag, ".out_valid"}, 64'(out_valid), 64'd1);
        check({tag, ".opcode"},    64'(opcode), 64'(v.op));
        check({tag, ".type"},      64'(instr_type), 64'(v.typ));
        check({tag, ".imm"},       64'(immediate), 64'(v.imm));
        check({tag, ".shamt"},     64'(shamt), 64'(v.shamt));
        check({tag, ".rs1"},       64'(rs1), 64'(v.rs1));
        check({tag, ".rs2"},       64'(rs2), 64'(v.rs2));
        check({tag, ".rd"},        64'(rd), 64'(v.rd));
        check({tag, ".word_op"},   64'(word_op), 64'(v.word_op));
        check({tag, ".illegal"},   64'(illegal), 64'(v.illegal));
    endtask

    // Driver: present one instruction on the input side.
    task automatic drive(input logic v, input logic [31:0] i, input logic [63:0] pc);
        in_valid = v;
        instr    = i;
        in_pc    = pc;
    endtask

    task automatic check_counts(input string tag);
        check({tag, ".issued_cnt"},  64'(issued_cnt), 64'(exp_iss));
        check({tag, ".illegal_cnt"}, 64'(illegal_cnt), 64'(exp_ill));
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        exp_iss = '0; exp_ill = '0;
        reset_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'd0, 64'd0);

        vecs[0]  = mk(I_ADDI,       OP_ADD,     T_I,    32'hFFFFFFFB, 6'd0,  5'd0,  5'd27, 5'd1, 1'b0, 1'b0);
        vecs[1]  = mk(I_MUL,        OP_MUL,     T_R,    32'h0,        6'd0,  5'd1,  5'd2,  5'd3, 1'b0, 1'b0);
        vecs[2]  = mk(I_SRAI,       OP_SRA,     T_I,    32'h43F,      6'd63, 5'd6,  5'd31, 5'd5, 1'b0, 1'b0);
        vecs[3]  = mk(32'h0201109B, OP_NOTHING, T_NONE, 32'h0,        6'd0,  5'd2,  5'd0,  5'd1, 1'b0, 1'b1);
        vecs[4]  = mk(I_ONES,       OP_NOTHING, T_NONE, 32'h0,        6'd0,  5'd31, 5'd31, 5'd31, 1'b0, 1'b1);
        vecs[5]  = mk(32'hFE20AE23, OP_ADD,     T_S,    32'hFFFFFFFC, 6'd0,  5'd1,  5'd2,  5'd0, 1'b0, 1'b0);
        vecs[6]  = mk(32'hFE20FCE3, OP_GTEU,    T_B,    32'hFFFFFFF8, 6'd0,  5'd1,  5'd2,  5'd0, 1'b0, 1'b0);
        vecs[7]  = mk(I_LUI,        OP_IMMVAL,  T_U,    32'h12345000, 6'd0,  5'd0,  5'd0,  5'd7, 1'b0, 1'b0);
        vecs[8]  = mk(32'h4062823B, OP_SUB,     T_R,    32'h0,        6'd0,  5'd5,  5'd6,  5'd4, 1'b1, 1'b0);
        vecs[9]  = mk(32'h010000EF, OP_NOTHING, T_J,    32'h10,       6'd0,  5'd0,  5'd0,  5'd1, 1'b0, 1'b0);
        vecs[10] = mk(32'h00813403, OP_ADD,     T_I,    32'h8,        6'd0,  5'd2,  5'd8,  5'd8, 1'b0, 1'b0);
        vecs[11] = mk(32'h00113093, OP_SLTIU,   T_I,    32'h1,        6'd0,  5'd2,  5'd1,  5'd1, 1'b0, 1'b0);
        vecs[12] = mk(32'h0220D1BB, OP_DIVU,    T_R,    32'h0,        6'd0,  5'd1,  5'd2,  5'd3, 1'b1, 1'b0);
        vecs[13] = mk(32'h0020C1BB, OP_NOTHING, T_NONE, 32'h0,        6'd0,  5'd1,  5'd2,  5'd3, 1'b0, 1'b1);
        vecs[14] = mk(32'h00000001, OP_NOTHING, T_NONE, 32'h0,        6'd0,  5'd0,  5'd0,  5'd0, 1'b0, 1'b1);
        vecs[15] = mk(32'h01F1109B, OP_SLL,     T_I,    32'h1F,       6'd31, 5'd2,  5'd31, 5'd1, 1'b1, 1'b0);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.opcode", 64'(opcode), 64'(OP_NOTHING));
        check("rst.imm", 64'(immediate), 64'd0);
        check("rst.in_ready", 64'(in_ready), 64'd1);
        check_counts("rst");
        reset_n = 1'b1;

        // Vector table: back-to-back stream with out_ready held high
        out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            drive(1'b1, vecs[i].instr, 64'hFFFF_0000_0000_1000 + 64'(i * 4));
            exp_q.push_back(64'hFFFF_0000_0000_1000 + 64'(i * 4));
            @(posedge clk);
            @(negedge clk);
            if (i > 0) begin
                exp_iss = exp_iss + 1'b1;
                if (vecs[i-1].illegal) exp_ill = exp_ill + 1'b1;
            end
            check_fields($sformatf("v%0d", i), vecs[i]);
            check($sformatf("v%0d.out_pc", i), out_pc, exp_q.pop_front());
            check($sformatf("v%0d.in_ready", i), 64'(in_ready), 64'd1);
            check_counts($sformatf("v%0d", i));
        end
        drive(1'b0, 32'd0, 64'd0);
        @(posedge clk);
        @(negedge clk);
        exp_iss = exp_iss + 1'b1;
        if (vecs[NV-1].illegal) exp_ill = exp_ill + 1'b1;
        check("drain.out_valid", 64'(out_valid), 64'd0);
        check_counts("drain");

        // Backpressure: SRAI held for 3 cycles while ADDI waits
        out_ready = 1'b0;
        drive(1'b1, I_SRAI, 64'h2000);
        @(posedge clk);
        @(negedge clk);
        drive(1'b1, I_ADDI, 64'h2004);
        for (int c = 0; c < 3; c++) begin
            check_fields($sformatf("bp%0d", c), vecs[2]);
            check($sformatf("bp%0d.out_pc", c), out_pc, 64'h2000);
            check($sformatf("bp%0d.in_ready", c), 64'(in_ready), 64'd0);
            @(posedge clk);
            @(negedge clk);
        end
        check_counts("bp_hold");
        out_ready = 1'b1;
        #1;
        check("bp_rel.in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        exp_iss = exp_iss + 1'b1;
        check_fields("bp_next", vecs[0]);
        check("bp_next.out_pc", out_pc, 64'h2004);
        check_counts("bp_next");

        // Flush with out_ready low: nothing accepted, counters unchanged
        out_ready = 1'b0;
        flush = 1'b1;
        drive(1'b1, I_MUL, 64'h3000);
        @(posedge clk);
        @(negedge clk);
        check("fl0.out_valid", 64'(out_valid), 64'd0);
        check_counts("fl0");
        flush = 1'b0;
        drive(1'b0, 32'd0, 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("fl0b.out_valid", 64'(out_valid), 64'd0);
        check_counts("fl0b");

        // Flush with out_ready high: handshake counts, new word dropped
        drive(1'b1, I_MUL, 64'h3004);
        @(posedge clk);
        @(negedge clk);
        check_fields("fl1_load", vecs[1]);
        flush = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, I_LUI, 64'h3008);
        @(posedge clk);
        @(negedge clk);
        exp_iss = exp_iss + 1'b1;
        check("fl1.out_valid", 64'(out_valid), 64'd0);
        check("fl1.out_pc", out_pc, 64'h3004);
        check_counts("fl1");
        flush = 1'b0;
        drive(1'b0, 32'd0, 64'd0);

        // Reset mid-stream while an instruction is held
        out_ready = 1'b0;
        drive(1'b1, I_LUI, 64'h4000);
        @(posedge clk);
        @(negedge clk);
        check("mr_pre.out_valid", 64'(out_valid), 64'd1);
        reset_n = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        exp_iss = '0; exp_ill = '0;
        check("mr.out_valid", 64'(out_valid), 64'd0);
        check("mr.opcode", 64'(opcode), 64'(OP_NOTHING));
        check("mr.imm", 64'(immediate), 64'd0);
        check("mr.rd", 64'(rd), 64'd0);
        check_counts("mr");
        reset_n = 1'b1;

        // Counter wrap: 16 handshakes, every other word illegal
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, (k % 2 == 0) ? I_ADDI : I_ONES, 64'h5000 + 64'(k * 4));
            @(posedge clk);
            @(negedge clk);
            if (k > 0) begin
                exp_iss = exp_iss + 1'b1;
                if (k % 2 == 0) exp_ill = exp_ill + 1'b1;
            end
        end
        check("wrap15.issued_cnt", 64'(issued_cnt), 64'd15);
        check_counts("wrap15");
        drive(1'b0, 32'd0, 64'd0);
        @(posedge clk);
        @(negedge clk);
        exp_iss = exp_iss + 1'b1;
        exp_ill = exp_ill + 1'b1;
        check("wrap.issued_cnt", 64'(issued_cnt), 64'd0);
        check("wrap.illegal_cnt", 64'(illegal_cnt), 64'd8);
        check_counts("wrap");
        check("wrap.out_valid", 64'(out_valid), 64'd0);

        // Final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
